bchecc_enc_ctrl: RTL and testbench

- Sequencer for the BCH parity encoder in the NFC ECC path.
- Accepts one sector of data bytes from the NFC write datapath and drives the encoder's init, data-valid, last-byte and parity-shift controls.
- Owns the byte mux into the encoder.
- Emits the parity bytes as a valid-only stream to the NAND write FIFO, then signals completion.

---
 rtl/bchecc_pkg.sv | 40 ++++
 rtl/bchecc_enc_ctrl_par_cnt.sv | 57 +++++
 rtl/bchecc_enc_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_bchecc_enc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bchecc_pkg.sv
// bchecc_pkg
//   Shared definitions for the BCH encoder sequencer in the NFC ECC path.
//   Contents:
//     state_e          - sequencer FSM encoding (IDLE, INIT, DATA, PARITY, FLUSH)
//     PAR_BITS_*       - parity bit counts of the short and long codes
//     PAR_BYTES_*      - parity byte counts (bits rounded up to whole bytes)
//     PCNT_W           - width of the parity byte counter
//     par_bytes()      - parity byte count for the selected code
package bchecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

  localparam int PAR_BITS_SHORT  = 104;
  localparam int PAR_BITS_LONG   = 195;

  // The long code does not fill its last byte; the encoder packs the
  // leftover bits together with the final data byte, so round up.
  localparam int PAR_BYTES_SHORT = (PAR_BITS_SHORT + 7) / 8;  // 13
  localparam int PAR_BYTES_LONG  = (PAR_BITS_LONG + 7) / 8;   // 25

  localparam int PCNT_W = 5;

  // Number of parity bytes shifted out for the given code selection.
  function automatic logic [PCNT_W-1:0] par_bytes(input logic long_mode);
    logic [PCNT_W-1:0] n;
    if (long_mode) begin
      n = PCNT_W'(PAR_BYTES_LONG);
    end else begin
      n = PCNT_W'(PAR_BYTES_SHORT);
    end
    return n;
  endfunction

endpackage

// File: rtl/bchecc_enc_ctrl_par_cnt.sv
// bchecc_par_cnt
//   Parity byte counter for the BCH encoder sequencer. Counts parity shift
//   strobes and flags the first strobe, the final strobe and whether more
//   strobes are still owed for the selected code.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     clr_i     - synchronous clear (start of a sector)
//     en_i      - one parity shift strobe issued this cycle
//     long_i    - code selection (0 short, 1 long)
//     below_o   - count is below the parity byte count of the code
//     first_o   - count is zero (next strobe is the first)
//     last_o    - next strobe is the final one
module bchecc_par_cnt
  import bchecc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic long_i,
  output logic below_o,
  output logic first_o,
  output logic last_o
);

  logic [PCNT_W-1:0] cnt_q;
  logic [PCNT_W-1:0] cnt_d;
  logic [PCNT_W-1:0] pbytes;

  assign pbytes = par_bytes(long_i);

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + PCNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign below_o = (cnt_q < pbytes);
  assign first_o = (cnt_q == '0);
  assign last_o  = (cnt_q == (pbytes - PCNT_W'(1)));

endmodule

// File: rtl/bchecc_enc_ctrl.sv
// bchecc_enc_ctrl
//   Sequencer for the BCH parity encoder in the NFC ECC path. Takes one
//   sector of data bytes, drives the encoder init / data-valid / last-byte /
//   parity-shift controls, owns the byte mux into the encoder and streams
//   the parity bytes (valid-only) to the NAND write FIFO.
//   Parameters:
//     DATA_BYTES - data bytes per sector (>= 2)
//     CNT_W      - data counter width (2**CNT_W >= DATA_BYTES)
//   Ports:
//     clk, rst             - clock, asynchronous active-high reset
//     start_i, abort_i     - begin a sector (IDLE only) / abandon it
//     ecc_opt_i            - code select, captured on an accepted start
//     din_i, din_valid_i   - sector data in; din_ready_o accepts it
//     par_ready_i          - parity sink can take a byte next cycle
//     enc_par_i            - registered parity byte from the encoder
//     ecc_opt_o            - latched code select to the encoder
//     ecc_data_o           - byte into the encoder
//     init_en_o            - encoder clear
//     enc_data_avail_o     - encoder absorbs ecc_data_o
//     enc_last_o           - final data byte of the sector
//     enc_out_en_o         - encoder parity shift/load
//     enc_out_first_o      - first parity shift of the sector
//     par_o, par_valid_o   - parity byte stream (sink must take it)
//     busy_o, done_o       - not idle / one-cycle sector-complete pulse
module bchecc_enc_ctrl
  import bchecc_pkg::*;
#(
  parameter int DATA_BYTES = 512,
  parameter int CNT_W      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       ecc_opt_i,
  input  logic [7:0] din_i,
  input  logic       din_valid_i,
  output logic       din_ready_o,
  input  logic       par_ready_i,
  input  logic [7:0] enc_par_i,
  output logic       ecc_opt_o,
  output logic [7:0] ecc_data_o,
  output logic       init_en_o,
  output logic       enc_data_avail_o,
  output logic       enc_last_o,
  output logic       enc_out_en_o,
  output logic       enc_out_first_o,
  output logic [7:0] par_o,
  output logic       par_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DATA_BYTES - 1);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] dcnt_q,      dcnt_d;
  logic [7:0]       last_byte_q, last_byte_d;
  logic             ecc_opt_q,   ecc_opt_d;
  logic             par_valid_q, par_valid_d;
  logic             done_q,      done_d;

  logic pcnt_clr;
  logic pcnt_below;
  logic pcnt_first;
  logic pcnt_last;

  bchecc_par_cnt u_par_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pcnt_clr),
    .en_i    (enc_out_en_o),
    .long_i  (ecc_opt_q),
    .below_o (pcnt_below),
    .first_o (pcnt_first),
    .last_o  (pcnt_last)
  );

  // Next-state and encoder control decode. An abort suppresses every
  // avail/out strobe in its own cycle so init_en_o never overlaps them.
  always_comb begin
    state_d          = state_q;
    dcnt_d           = dcnt_q;
    last_byte_d      = last_byte_q;
    ecc_opt_d        = ecc_opt_q;
    done_d           = 1'b0;
    pcnt_clr         = 1'b0;
    din_ready_o      = 1'b0;
    ecc_data_o       = 8'h00;
    init_en_o        = 1'b0;
    enc_data_avail_o = 1'b0;
    enc_last_o       = 1'b0;
    enc_out_en_o     = 1'b0;
    enc_out_first_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d   = ST_INIT;
          ecc_opt_d = ecc_opt_i;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_INIT: begin
        init_en_o = 1'b1;
        pcnt_clr  = 1'b1;
        dcnt_d    = '0;
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        ecc_data_o = din_i;
        if (abort_i) begin
          init_en_o = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          din_ready_o      = 1'b1;
          enc_data_avail_o = din_valid_i;
          if (din_valid_i) begin
            dcnt_d      = dcnt_q + CNT_W'(1);
            last_byte_d = din_i;
            // Exact match: the FSM leaves DATA here, so dcnt never wraps.
            if (dcnt_q == DCNT_LAST) begin
              enc_last_o = 1'b1;
              state_d    = ST_PARITY;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_PARITY: begin
        // Encoder needs the final data byte on its input while shifting;
        // the long code merges its low bits into the first parity byte.
        ecc_data_o = last_byte_q;
        if (abort_i) begin
          init_en_o = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          enc_out_en_o    = par_ready_i & pcnt_below;
          enc_out_first_o = enc_out_en_o & pcnt_first;
          if (enc_out_en_o && pcnt_last) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_PARITY;
          end
        end
      end

      ST_FLUSH: begin
        // The last parity byte is on par_o this cycle; done follows it.
        state_d = ST_IDLE;
        if (abort_i) begin
          init_en_o = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The encoder output register lags the shift strobe by one cycle.
    par_valid_d = enc_out_en_o;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dcnt_q      <= '0;
      last_byte_q <= 8'h00;
      ecc_opt_q   <= 1'b0;
      par_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      last_byte_q <= last_byte_d;
      ecc_opt_q   <= ecc_opt_d;
      par_valid_q <= par_valid_d;
      done_q      <= done_d;
    end
  end

  assign ecc_opt_o   = ecc_opt_q;
  assign par_valid_o = par_valid_q;
  assign par_o       = par_valid_q ? enc_par_i : 8'h00;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_bchecc_enc_ctrl.sv
// Testbench for bchecc_enc_ctrl with a behavioural encoder stand-in.
// The stand-in hashes absorbed bytes and emits one keyed byte per parity
// strobe; the scoreboard derives the expected parity stream from the
// sector data and compares it against par_o whenever par_valid_o is high.
module tb_bchecc_enc_ctrl;

  localparam int DB = 4;
  localparam int CW = 3;

  logic       clk, rst;
  logic       start_i, abort_i, ecc_opt_i, din_valid_i, par_ready_i;
  logic [7:0] din_i, enc_par_i;
  logic       din_ready_o, ecc_opt_o, init_en_o, enc_data_avail_o, enc_last_o;
  logic       enc_out_en_o, enc_out_first_o, par_valid_o, busy_o, done_o;
  logic [7:0] ecc_data_o, par_o;

  int         n_cmp, n_err;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last;
  int         av_cnt, oe_cnt, pv_cnt, dn_cnt, last_cnt, sec_oe;
  int         gcyc, pv_cyc, dn_cyc;
  logic       prev_oe, obs_init;
  logic [31:0] stub_h;
  logic [7:0]  stub_k;

  bchecc_enc_ctrl #(.DATA_BYTES(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .ecc_opt_i(ecc_opt_i), .din_i(din_i), .din_valid_i(din_valid_i),
    .din_ready_o(din_ready_o), .par_ready_i(par_ready_i), .enc_par_i(enc_par_i),
    .ecc_opt_o(ecc_opt_o), .ecc_data_o(ecc_data_o), .init_en_o(init_en_o),
    .enc_data_avail_o(enc_data_avail_o), .enc_last_o(enc_last_o),
    .enc_out_en_o(enc_out_en_o), .enc_out_first_o(enc_out_first_o),
    .par_o(par_o), .par_valid_o(par_valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hash_step(input logic [31:0] h, input logic [7:0] b);
    return {h[26:0], 5'b00000} + h + {24'h000000, b};
  endfunction

  // Parity byte k of the stand-in code; merge folds in the last data byte.
  function automatic logic [7:0] stub_byte(input logic [31:0] h, input logic [7:0] k,
                                           input logic merge, input logic [7:0] lb);
    logic [7:0] g;
    g = h[7:0] ^ h[15:8] ^ h[31:24] ^ (k * 8'd29) ^ 8'h5A;
    if (merge) g = {g[2:0], lb[4:0]};
    return g;
  endfunction

  // Encoder stand-in: index restarts only on the first strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_h <= 32'd0; stub_k <= 8'd0; enc_par_i <= 8'd0;
    end else if (init_en_o) begin
      stub_h <= 32'd0; stub_k <= 8'd7;
    end else if (enc_out_en_o) begin
      enc_par_i <= stub_byte(stub_h, enc_out_first_o ? 8'd0 : stub_k,
                             ecc_opt_o & enc_out_first_o, ecc_data_o);
      stub_k <= (enc_out_first_o ? 8'd0 : stub_k) + 8'd1;
    end else if (enc_data_avail_o) begin
      stub_h <= hash_step(stub_h, ecc_data_o);
    end
  end

  // One clock: observe on the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    gcyc++;
    n_cmp++;
    if ((enc_data_avail_o && enc_out_en_o) || (init_en_o && (enc_data_avail_o || enc_out_en_o))) begin
      n_err++; $display("FAIL strobe_excl: avail=%b out_en=%b init=%b, required no overlap", enc_data_avail_o, enc_out_en_o, init_en_o);
    end
    if (enc_data_avail_o) begin
      av_cnt++; n_cmp++;
      if (!(din_valid_i && din_ready_o)) begin n_err++; $display("FAIL avail_hs: valid=%b ready=%b, required 1/1", din_valid_i, din_ready_o); end
    end
    if (enc_last_o) begin
      last_cnt++; n_cmp++;
      if (ecc_data_o !== exp_last || !enc_data_avail_o) begin n_err++; $display("FAIL enc_last: data=%h avail=%b, required %h/1", ecc_data_o, enc_data_avail_o, exp_last); end
    end
    if (enc_out_en_o) begin
      n_cmp++;
      if (!par_ready_i || ecc_data_o !== exp_last) begin n_err++; $display("FAIL out_en: ready=%b data=%h, required 1/%h", par_ready_i, ecc_data_o, exp_last); end
      n_cmp++;
      if (enc_out_first_o !== (sec_oe == 0)) begin n_err++; $display("FAIL out_first: got %b on strobe %0d", enc_out_first_o, sec_oe); end
      sec_oe++; oe_cnt++;
    end else begin
      n_cmp++;
      if (enc_out_first_o !== 1'b0) begin n_err++; $display("FAIL out_first_alone: got 1, required 0"); end
    end
    if (par_valid_o) begin
      n_cmp++;
      if (!prev_oe) begin n_err++; $display("FAIL pv_no_outen: par_valid with no out_en before"); end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL pv_unexpected: par_o=%h, required no byte", par_o);
      end else begin
        e = exp_q.pop_front();
        if (par_o !== e) begin n_err++; $display("FAIL par_byte: got %h, required %h", par_o, e); end
      end
      pv_cnt++; pv_cyc = gcyc;
    end
    if (done_o) begin dn_cnt++; dn_cyc = gcyc; end
    prev_oe  = enc_out_en_o;
    obs_init = init_en_o;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ecc_opt_i = 1'b0;
    din_i = 8'hA5; din_valid_i = 1'b0; par_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    exp_q.delete(); prev_oe = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive one sector; abort_at >= 0 aborts after that many parity strobes.
  task automatic run_sector(input logic opt, input logic [31:0] dw, input bit bp,
                            input bit gap, input int abort_at, output bit done_seen);
    logic [31:0] h;
    int nexp, k, gap_left, post, base_av, base_dn;
    bit aborted;
    done_seen = 1'b0; aborted = 1'b0; post = 0;
    exp_last = dw[31:24];
    nexp = (abort_at >= 0) ? abort_at : (opt ? 25 : 13);
    h = 32'd0;
    for (int i = 0; i < DB; i++) h = hash_step(h, dw[8*i +: 8]);
    for (int i = 0; i < nexp; i++) exp_q.push_back(stub_byte(h, 8'(i), opt & (i == 0), dw[31:24]));
    sec_oe = 0; base_dn = dn_cnt;
    start_i = 1'b1; ecc_opt_i = opt; par_ready_i = 1'b1; din_valid_i = 1'b0;
    cycle();
    start_i = 1'b0; ecc_opt_i = ~opt;
    gap_left = gap ? 3 : 0; base_av = av_cnt;
    for (int c = 0; c < 300; c++) begin
      k = av_cnt - base_av;
      abort_i = 1'b0;
      if (gap && k == 2 && gap_left > 0) begin din_valid_i = 1'b0; din_i = 8'hEE; gap_left--; end
      else if (k < DB) begin din_valid_i = 1'b1; din_i = dw[8*k +: 8]; end
      else begin din_valid_i = 1'b0; din_i = 8'hEE; end
      par_ready_i = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (abort_at >= 0 && !aborted && sec_oe == abort_at) begin abort_i = 1'b1; aborted = 1'b1; end
      cycle();
      if (abort_i) begin
        n_cmp++; if (obs_init !== 1'b1) begin n_err++; $display("FAIL abort_init: init_en=%b, required 1", obs_init); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_idle: busy=%b, required 0", busy_o); end
      end
      if (aborted) post++;
      if (dn_cnt != base_dn) begin done_seen = 1'b1; break; end
      if (post > 8) break;
    end
    abort_i = 1'b0; din_valid_i = 1'b0; par_ready_i = 1'b1;
    if (!aborted) begin
      n_cmp++; if (!done_seen) begin n_err++; $display("FAIL timeout: done_o seen=0, required 1"); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ecc_opt_i = 1'b1;
    din_i = 8'hA5; din_valid_i = 1'b1; par_ready_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({busy_o, done_o, din_ready_o, ecc_opt_o, init_en_o, enc_data_avail_o, enc_last_o, enc_out_en_o, enc_out_first_o, par_valid_o} !== 10'd0) begin
      n_err++; $display("FAIL reset_ctrl: got %b, required 0", {busy_o, done_o, din_ready_o, ecc_opt_o, init_en_o, enc_data_avail_o, enc_last_o, enc_out_en_o, enc_out_first_o, par_valid_o}); end
    n_cmp++; if (par_o !== 8'h00) begin n_err++; $display("FAIL reset_par: got %h, required 00", par_o); end
    n_cmp++; if (ecc_data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h, required 00", ecc_data_o); end
    do_reset();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b, required 0", busy_o); end
  endtask

  task automatic test_short();
    int b_av, b_oe, b_pv, b_dn, b_last; bit ok;
    b_av = av_cnt; b_oe = oe_cnt; b_pv = pv_cnt; b_dn = dn_cnt; b_last = last_cnt;
    run_sector(1'b0, 32'h04030201, 1'b0, 1'b0, -1, ok);
    n_cmp++; if (av_cnt - b_av != 4) begin n_err++; $display("FAIL short_avail: got %0d, required 4", av_cnt - b_av); end
    n_cmp++; if (last_cnt - b_last != 1) begin n_err++; $display("FAIL short_last: got %0d, required 1", last_cnt - b_last); end
    n_cmp++; if (oe_cnt - b_oe != 13) begin n_err++; $display("FAIL short_outen: got %0d, required 13", oe_cnt - b_oe); end
    n_cmp++; if (pv_cnt - b_pv != 13) begin n_err++; $display("FAIL short_pv: got %0d, required 13", pv_cnt - b_pv); end
    n_cmp++; if (dn_cyc != pv_cyc + 1) begin n_err++; $display("FAIL short_done_time: done cycle %0d, required %0d", dn_cyc, pv_cyc + 1); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL short_left: %0d bytes owed, required 0", exp_q.size()); end
    cycle();
    n_cmp++; if (dn_cnt - b_dn != 1) begin n_err++; $display("FAIL short_done_pulse: got %0d, required 1", dn_cnt - b_dn); end
  endtask

  task automatic test_long();
    int b_oe, b_pv; bit ok;
    b_oe = oe_cnt; b_pv = pv_cnt;
    run_sector(1'b1, 32'hD7C3B2A1, 1'b0, 1'b0, -1, ok);
    n_cmp++; if (oe_cnt - b_oe != 25) begin n_err++; $display("FAIL long_outen: got %0d, required 25", oe_cnt - b_oe); end
    n_cmp++; if (pv_cnt - b_pv != 25) begin n_err++; $display("FAIL long_pv: got %0d, required 25", pv_cnt - b_pv); end
    n_cmp++; if (ecc_opt_o !== 1'b1) begin n_err++; $display("FAIL long_opt: got %b, required 1", ecc_opt_o); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL long_left: %0d bytes owed, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int b_oe, b_pv; bit ok;
    b_oe = oe_cnt; b_pv = pv_cnt;
    run_sector(1'b0, 32'h44332211, 1'b1, 1'b0, -1, ok);
    n_cmp++; if (oe_cnt - b_oe != 13) begin n_err++; $display("FAIL bp_outen: got %0d, required 13", oe_cnt - b_oe); end
    n_cmp++; if (pv_cnt - b_pv != 13) begin n_err++; $display("FAIL bp_pv: got %0d, required 13", pv_cnt - b_pv); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_left: %0d bytes owed, required 0", exp_q.size()); end
  endtask

  task automatic test_input_gap();
    int b_av, b_pv; bit ok;
    b_av = av_cnt; b_pv = pv_cnt;
    run_sector(1'b0, 32'h04030201, 1'b0, 1'b1, -1, ok);
    n_cmp++; if (av_cnt - b_av != 4) begin n_err++; $display("FAIL gap_avail: got %0d, required 4", av_cnt - b_av); end
    n_cmp++; if (pv_cnt - b_pv != 13) begin n_err++; $display("FAIL gap_pv: got %0d, required 13", pv_cnt - b_pv); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL gap_left: %0d bytes owed, required 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    int b_oe, b_pv, b_dn; bit ok;
    b_oe = oe_cnt; b_pv = pv_cnt; b_dn = dn_cnt;
    run_sector(1'b0, 32'h0F1E2D3C, 1'b0, 1'b0, 5, ok);
    n_cmp++; if (oe_cnt - b_oe != 5) begin n_err++; $display("FAIL abort_outen: got %0d, required 5", oe_cnt - b_oe); end
    n_cmp++; if (pv_cnt - b_pv != 5) begin n_err++; $display("FAIL abort_pv: got %0d, required 5", pv_cnt - b_pv); end
    n_cmp++; if (dn_cnt != b_dn) begin n_err++; $display("FAIL abort_done: got %0d pulses, required 0", dn_cnt - b_dn); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL abort_left: %0d bytes owed, required 0", exp_q.size()); end
    b_pv = pv_cnt;
    run_sector(1'b0, 32'h04030201, 1'b0, 1'b0, -1, ok);
    n_cmp++; if (pv_cnt - b_pv != 13) begin n_err++; $display("FAIL after_abort_pv: got %0d, required 13", pv_cnt - b_pv); end
  endtask

  task automatic test_back_to_back();
    int b_dn, b_pv; bit ok1, ok2;
    b_dn = dn_cnt; b_pv = pv_cnt;
    run_sector(1'b0, 32'h5566AA99, 1'b0, 1'b0, -1, ok1);
    run_sector(1'b1, 32'h13579BDF, 1'b1, 1'b0, -1, ok2);
    n_cmp++; if (dn_cnt - b_dn != 2) begin n_err++; $display("FAIL b2b_done: got %0d, required 2", dn_cnt - b_dn); end
    n_cmp++; if (pv_cnt - b_pv != 38) begin n_err++; $display("FAIL b2b_pv: got %0d, required 38", pv_cnt - b_pv); end
  endtask

  task automatic test_corners();
    // start while busy is ignored
    exp_last = 8'h00;
    start_i = 1'b1; ecc_opt_i = 1'b0; din_valid_i = 1'b0; cycle();
    start_i = 1'b0; cycle();
    start_i = 1'b1; ecc_opt_i = 1'b1; cycle();
    start_i = 1'b0;
    n_cmp++; if (ecc_opt_o !== 1'b0) begin n_err++; $display("FAIL busy_start_opt: got %b, required 0", ecc_opt_o); end
    n_cmp++; if (din_ready_o !== 1'b1 || busy_o !== 1'b1) begin n_err++; $display("FAIL busy_start_state: ready=%b busy=%b, required 1/1", din_ready_o, busy_o); end
    abort_i = 1'b1; cycle(); abort_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL data_abort: busy=%b, required 0", busy_o); end
    // start with abort in IDLE stays idle
    start_i = 1'b1; abort_i = 1'b1; ecc_opt_i = 1'b1; cycle();
    start_i = 1'b0; abort_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0 || ecc_opt_o !== 1'b0) begin n_err++; $display("FAIL start_abort: busy=%b opt=%b, required 0/0", busy_o, ecc_opt_o); end
    cycle();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL start_abort_hold: busy=%b, required 0", busy_o); end
    // reset in the middle of DATA
    start_i = 1'b1; ecc_opt_i = 1'b1; cycle(); start_i = 1'b0;
    din_valid_i = 1'b1; din_i = 8'h31; cycle(); cycle(); din_i = 8'h32; cycle();
    n_cmp++; if (din_ready_o !== 1'b1 || ecc_opt_o !== 1'b1) begin n_err++; $display("FAIL pre_reset: ready=%b opt=%b, required 1/1", din_ready_o, ecc_opt_o); end
    rst = 1'b1; #1;
    n_cmp++; if ({busy_o, done_o, din_ready_o, ecc_opt_o, init_en_o, enc_data_avail_o, enc_last_o, enc_out_en_o, enc_out_first_o, par_valid_o} !== 10'd0) begin
      n_err++; $display("FAIL midreset_ctrl: got %b, required 0", {busy_o, done_o, din_ready_o, ecc_opt_o, init_en_o, enc_data_avail_o, enc_last_o, enc_out_en_o, enc_out_first_o, par_valid_o}); end
    n_cmp++; if (ecc_data_o !== 8'h00 || par_o !== 8'h00) begin n_err++; $display("FAIL midreset_data: data=%h par=%h, required 00/00", ecc_data_o, par_o); end
    do_reset();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    av_cnt = 0; oe_cnt = 0; pv_cnt = 0; dn_cnt = 0; last_cnt = 0; sec_oe = 0;
    gcyc = 0; pv_cyc = 0; dn_cyc = 0; prev_oe = 1'b0; obs_init = 1'b0; exp_last = 8'h00;
    test_reset();
    test_short();
    test_long();
    test_backpressure();
    test_input_gap();
    test_abort();
    test_corners();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
